axi_block_bridge: RTL and testbench

Memory-side counterpart of the core's cache-block request interface. It accepts the single-line block requests issued by the core (`read_start`, `write_start`, block address, 512-bit block) and converts each one into one AXI4 INCR burst on a narrow data bus. It returns the filled block plus a one-cycle `done` pulse. It sits between the core top level and the system AXI interconnect/memory.

---
 rtl/axi_block_pkg.sv | 20 ++
 rtl/axi_block_bridge_if.sv | 66 ++++++
 rtl/axi_block_bridge.sv | 136 +++++++++++++
 tb/tb_axi_block_bridge.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_block_pkg.sv
// Shared types and constants for the cache-block to AXI4 burst bridge.
package axi_block_pkg;

  localparam int BEATS      = 512 / 64;
  localparam int BEAT_CNT_W = $clog2(BEATS);

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } bridge_state_t;

endpackage

// File: rtl/axi_block_bridge_if.sv
// AXI4 write/read channels between the block bridge (master) and memory (slave).
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; once valid is raised it stays high with
// a stable payload until that edge, and valid never waits for ready.
interface axi_block_bridge_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int AXI_DATA_W = 64
) ();

  logic                      awvalid_o;
  logic                      awready_i;
  logic [ADDR_WIDTH-1:0]     awaddr_o;
  logic [7:0]                awlen_o;
  logic [2:0]                awsize_o;
  logic [1:0]                awburst_o;

  logic                      wvalid_o;
  logic                      wready_i;
  logic [AXI_DATA_W-1:0]     wdata_o;
  logic [AXI_DATA_W/8-1:0]   wstrb_o;
  logic                      wlast_o;

  logic                      bvalid_i;
  logic                      bready_o;
  logic [1:0]                bresp_i;

  logic                      arvalid_o;
  logic                      arready_i;
  logic [ADDR_WIDTH-1:0]     araddr_o;
  logic [7:0]                arlen_o;
  logic [2:0]                arsize_o;
  logic [1:0]                arburst_o;

  logic                      rvalid_i;
  logic                      rready_o;
  logic [AXI_DATA_W-1:0]     rdata_i;
  logic                      rlast_i;
  logic [1:0]                rresp_i;

  modport master (
    output awvalid_o, awaddr_o, awlen_o, awsize_o, awburst_o,
    input  awready_i,
    output wvalid_o, wdata_o, wstrb_o, wlast_o,
    input  wready_i,
    input  bvalid_i, bresp_i,
    output bready_o,
    output arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o,
    input  arready_i,
    input  rvalid_i, rdata_i, rlast_i, rresp_i,
    output rready_o
  );

  modport slave (
    input  awvalid_o, awaddr_o, awlen_o, awsize_o, awburst_o,
    output awready_i,
    input  wvalid_o, wdata_o, wstrb_o, wlast_o,
    output wready_i,
    output bvalid_i, bresp_i,
    input  bready_o,
    input  arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o,
    output arready_i,
    output rvalid_i, rdata_i, rlast_i, rresp_i,
    input  rready_o
  );

endinterface

// File: rtl/axi_block_bridge.sv
// Converts one cache-block read or write-back request into a single AXI4 INCR
// burst and pulses done_o for one cycle when it completes. Every AXI output is
// decoded from the state register, beat counter or latched request, so there
// is no combinational path from any incoming valid/ready to an output.
module axi_block_bridge
  import axi_block_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int AXI_DATA_W  = 64
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   read_start_i,
  input  logic                   write_start_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [BLOCK_WIDTH-1:0] data_block_i,
  output logic [BLOCK_WIDTH-1:0] data_block_o,
  output logic                   done_o,
  output bridge_state_t          state_o,
  axi_block_bridge_if.master     axi
);

  localparam int               NBEATS     = BLOCK_WIDTH / AXI_DATA_W;
  localparam int               CNT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(NBEATS - 1);
  localparam logic [7:0]       BURST_LEN  = 8'(NBEATS - 1);
  localparam logic [2:0]       BURST_SIZE = 3'($clog2(AXI_DATA_W / 8));

  bridge_state_t          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0] wblk_q, wblk_d;
  logic [BLOCK_WIDTH-1:0] rbuf_q, rbuf_d;

  logic w_fire;
  logic r_fire;

  assign w_fire = (state_q == ST_W) && axi.wready_i;
  assign r_fire = (state_q == ST_R) && axi.rvalid_i;

  // State register; an asynchronous reset abandons any burst in flight.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: write-back wins over read when both are requested.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (write_start_i)     state_d = ST_AW;
        else if (read_start_i) state_d = ST_AR;
      end
      ST_AW:   if (axi.awready_i) state_d = ST_W;
      ST_W:    if (w_fire && (cnt_q == LAST_BEAT)) state_d = ST_B;
      ST_B:    if (axi.bvalid_i) state_d = ST_DONE;
      ST_AR:   if (axi.arready_i) state_d = ST_R;
      // An early rlast still ends the burst; the beat count is not checked.
      ST_R:    if (r_fire && axi.rlast_i) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: request latch in IDLE, beat counter, read buffer fill.
  always_comb begin
    addr_d = addr_q;
    wblk_d = wblk_q;
    rbuf_d = rbuf_q;
    cnt_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (write_start_i) begin
          addr_d = addr_i;
          wblk_d = data_block_i;
        end else if (read_start_i) begin
          addr_d = addr_i;
        end
      end
      ST_W: begin
        cnt_d = w_fire ? (cnt_q + CNT_W'(1)) : cnt_q;
      end
      ST_R: begin
        cnt_d = cnt_q;
        if (r_fire) begin
          rbuf_d[int'(cnt_q)*AXI_DATA_W +: AXI_DATA_W] = axi.rdata_i;
          cnt_d = axi.rlast_i ? '0 : (cnt_q + CNT_W'(1));
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath registers; reset clears the read buffer and the latched request.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q  <= '0;
      addr_q <= '0;
      wblk_q <= '0;
      rbuf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      wblk_q <= wblk_d;
      rbuf_q <= rbuf_d;
    end
  end

  assign state_o       = state_q;
  assign done_o        = (state_q == ST_DONE);
  assign data_block_o  = rbuf_q;

  assign axi.awvalid_o = (state_q == ST_AW);
  assign axi.awaddr_o  = addr_q;
  assign axi.awlen_o   = BURST_LEN;
  assign axi.awsize_o  = BURST_SIZE;
  assign axi.awburst_o = AXI_BURST_INCR;

  assign axi.wvalid_o  = (state_q == ST_W);
  assign axi.wdata_o   = wblk_q[int'(cnt_q)*AXI_DATA_W +: AXI_DATA_W];
  assign axi.wstrb_o   = '1;
  assign axi.wlast_o   = (state_q == ST_W) && (cnt_q == LAST_BEAT);

  assign axi.bready_o  = (state_q == ST_B);

  assign axi.arvalid_o = (state_q == ST_AR);
  assign axi.araddr_o  = addr_q;
  assign axi.arlen_o   = BURST_LEN;
  assign axi.arsize_o  = BURST_SIZE;
  assign axi.arburst_o = AXI_BURST_INCR;

  assign axi.rready_o  = (state_q == ST_R);

endmodule

// File: tb/tb_axi_block_bridge.sv
// Bench for axi_block_bridge: a memory-side driver answers the bridge's AXI
// channels cycle by cycle, and a block-level model (expected beat queue and
// per-slot read buffer) supplies every expected value.
module tb_axi_block_bridge;
  import axi_block_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_i;
  logic          read_start_i;
  logic          write_start_i;
  logic [63:0]   addr_i;
  logic [511:0]  data_block_i;
  logic [511:0]  data_block_o;
  logic          done_o;
  bridge_state_t state_o;

  axi_block_bridge_if #(.ADDR_WIDTH(64), .AXI_DATA_W(64)) axi ();

  axi_block_bridge dut (
    .clk_i        (clk),
    .arst_i       (arst_i),
    .read_start_i (read_start_i),
    .write_start_i(write_start_i),
    .addr_i       (addr_i),
    .data_block_i (data_block_i),
    .data_block_o (data_block_o),
    .done_o       (done_o),
    .state_o      (state_o),
    .axi          (axi)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];      // expected W beats of the current write
  logic [63:0] obs_w_q[$];    // W beats accepted by the memory driver
  logic [63:0] rmem[8];       // data memory returns for beats 0..7
  logic [63:0] exp_rbuf[8];   // model of the bridge's last-read block slots

  int          aw_cnt, ar_cnt, wlast_cnt, wlast_beat, done_cyc, stall_cyc;
  int          unstable, wstrb_bad;
  logic [63:0] aw_addr_seen, ar_addr_seen;
  logic [7:0]  aw_len_seen, ar_len_seen;
  logic [2:0]  aw_size_seen, ar_size_seen;
  logic [1:0]  aw_burst_seen, ar_burst_seen;

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {$urandom, $urandom};
    return a & ~64'h3f;
  endfunction

  function automatic logic [511:0] pack_exp();
    logic [511:0] v;
    for (int k = 0; k < 8; k++) v[k*64 +: 64] = exp_rbuf[k];
    return v;
  endfunction

  function automatic void build_exp_w(input logic [511:0] blk);
    logic [511:0] t;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      t = blk >> (64 * k);
      exp_q.push_back(t[63:0]);
    end
  endfunction

  function automatic int w_beat_errs();
    int bad = 0;
    if (obs_w_q.size() != exp_q.size()) bad++;
    for (int k = 0; k < obs_w_q.size() && k < exp_q.size(); k++)
      if (obs_w_q[k] !== exp_q[k]) bad++;
    return bad;
  endfunction

  task automatic clear_slave();
    axi.awready_i = 1'b0; axi.wready_i = 1'b0; axi.bvalid_i = 1'b0; axi.bresp_i = 2'b00;
    axi.arready_i = 1'b0; axi.rvalid_i = 1'b0; axi.rdata_i  = '0;   axi.rlast_i = 1'b0;
    axi.rresp_i   = 2'b00;
  endtask

  // ---------------- driver ----------------
  // mode 0: no backpressure; 1: random stalls; 2: wready low once on odd beats,
  // arready held low for 3 cycles. Returns at done_o, on the abort beat, or timeout.
  task automatic do_txn(input bit wr, input bit rd, input logic [63:0] addr,
                        input logic [511:0] blk, input int mode, input int last_beat,
                        input int abort_beat);
    int cyc, wbeat, rbeat, arwait;
    bit fin, wstalled, pend_aw, pend_w, pend_ar, s_wlast;
    logic [63:0] s_awaddr, s_wdata, s_araddr;
    obs_w_q.delete();
    aw_cnt = 0; ar_cnt = 0; wlast_cnt = 0; wlast_beat = -1; done_cyc = -1;
    stall_cyc = 0; unstable = 0; wstrb_bad = 0;
    cyc = 0; wbeat = 0; rbeat = 0; arwait = 0; fin = 0; wstalled = 0;
    pend_aw = 0; pend_w = 0; pend_ar = 0; s_wlast = 0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0;
    @(negedge clk);
    write_start_i = wr; read_start_i = rd; addr_i = addr; data_block_i = blk;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      // Request inputs move while busy; the bridge must keep what it latched.
      addr_i = rand_addr();
      data_block_i = rand_block();
      clear_slave();
      axi.bresp_i = 2'($urandom);
      axi.rresp_i = 2'($urandom);
      if (pend_aw && (!axi.awvalid_o || axi.awaddr_o !== s_awaddr)) unstable++;
      if (pend_w && (!axi.wvalid_o || axi.wdata_o !== s_wdata || axi.wlast_o !== s_wlast))
        unstable++;
      if (pend_ar && (!axi.arvalid_o || axi.araddr_o !== s_araddr)) unstable++;
      pend_aw = 0; pend_w = 0; pend_ar = 0;
      if (done_o) begin
        done_cyc = cyc; fin = 1;
        write_start_i = 1'b0; read_start_i = 1'b0;
      end
      if (axi.awvalid_o) begin
        axi.awready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (axi.awready_i) begin
          aw_cnt++; aw_addr_seen = axi.awaddr_o; aw_len_seen = axi.awlen_o;
          aw_size_seen = axi.awsize_o; aw_burst_seen = axi.awburst_o;
        end else begin
          stall_cyc++; pend_aw = 1; s_awaddr = axi.awaddr_o;
        end
      end
      if (axi.wvalid_o) begin
        if (mode == 1) axi.wready_i = 1'($urandom_range(0, 1));
        else if (mode == 2 && (wbeat % 2 == 1) && !wstalled) begin
          axi.wready_i = 1'b0; wstalled = 1;
        end else axi.wready_i = 1'b1;
        if (axi.wready_i) begin
          obs_w_q.push_back(axi.wdata_o);
          if (axi.wstrb_o !== 8'hff) wstrb_bad++;
          if (axi.wlast_o) begin wlast_cnt++; wlast_beat = wbeat; end
          wbeat++; wstalled = 0;
        end else begin
          stall_cyc++; pend_w = 1; s_wdata = axi.wdata_o; s_wlast = axi.wlast_o;
        end
      end
      if (axi.bready_o) begin
        axi.bvalid_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!axi.bvalid_i) stall_cyc++;
      end
      if (axi.arvalid_o) begin
        if (mode == 1) axi.arready_i = 1'($urandom_range(0, 1));
        else if (mode == 2) axi.arready_i = (arwait >= 3);
        else axi.arready_i = 1'b1;
        arwait++;
        if (axi.arready_i) begin
          ar_cnt++; ar_addr_seen = axi.araddr_o; ar_len_seen = axi.arlen_o;
          ar_size_seen = axi.arsize_o; ar_burst_seen = axi.arburst_o;
        end else begin
          stall_cyc++; pend_ar = 1; s_araddr = axi.araddr_o;
        end
      end
      if (axi.rready_o) begin
        axi.rvalid_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (axi.rvalid_i) begin
          axi.rdata_i = (rbeat < 8) ? rmem[rbeat] : 64'h0;
          axi.rlast_i = (rbeat == last_beat);
          if (rbeat < 8) exp_rbuf[rbeat] = axi.rdata_i;
          if (rbeat == abort_beat) fin = 1;
          rbeat++;
        end else stall_cyc++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arst_i = 1'b1; read_start_i = 1'b0; write_start_i = 1'b0;
    addr_i = '0; data_block_i = '0;
    clear_slave();
    for (int k = 0; k < 8; k++) exp_rbuf[k] = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (state_o !== ST_IDLE) begin errors++;
      $display("FAIL reset_state got %0d exp %0d", state_o, ST_IDLE); end
    checks++;
    if ({axi.awvalid_o, axi.wvalid_o, axi.wlast_o, axi.bready_o, axi.arvalid_o,
         axi.rready_o, done_o} !== 7'b0) begin errors++;
      $display("FAIL reset_ctrl got %b exp 0", {axi.awvalid_o, axi.wvalid_o, axi.wlast_o,
               axi.bready_o, axi.arvalid_o, axi.rready_o, done_o}); end
    checks++;
    if ({axi.awaddr_o, axi.araddr_o, axi.wdata_o} !== 192'b0) begin errors++;
      $display("FAIL reset_addr_data got %h %h %h exp 0", axi.awaddr_o, axi.araddr_o,
               axi.wdata_o); end
    checks++;
    if (data_block_o !== 512'b0) begin errors++;
      $display("FAIL reset_block got %h exp 0", data_block_o); end
    arst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [511:0] blk;
    logic [511:0] held;
    for (int k = 0; k < 8; k++) blk[k*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(k);
    held = pack_exp();
    build_exp_w(blk);
    do_txn(1, 0, 64'h8000_0040, blk, 0, 7, -1);
    checks++;
    if (aw_cnt != 1 || ar_cnt != 0) begin errors++;
      $display("FAIL write_aw_count got aw %0d ar %0d exp aw 1 ar 0", aw_cnt, ar_cnt); end
    checks++;
    if ({aw_addr_seen, aw_len_seen, aw_size_seen, aw_burst_seen} !==
        {64'h8000_0040, 8'd7, 3'd3, 2'b01}) begin errors++;
      $display("FAIL write_aw_fields got %h len %0d size %0d burst %0d exp 80000040 7 3 1",
               aw_addr_seen, aw_len_seen, aw_size_seen, aw_burst_seen); end
    checks++;
    if (w_beat_errs() != 0) begin errors++;
      $display("FAIL write_beats got %0d bad of %0d exp 0 bad of 8", w_beat_errs(),
               obs_w_q.size()); end
    checks++;
    if (wlast_cnt != 1 || wlast_beat != 7 || wstrb_bad != 0) begin errors++;
      $display("FAIL write_wlast got cnt %0d beat %0d strb_bad %0d exp 1 7 0",
               wlast_cnt, wlast_beat, wstrb_bad); end
    checks++;
    if (done_cyc != 11) begin errors++;
      $display("FAIL write_latency got %0d exp 11", done_cyc); end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || state_o !== ST_IDLE) begin errors++;
      $display("FAIL write_done_pulse got done %b state %0d exp 0 0", done_o, state_o); end
    checks++;
    if (data_block_o !== held) begin errors++;
      $display("FAIL write_keeps_rbuf got %h exp %h", data_block_o, held); end
  endtask

  task automatic test_read();
    for (int k = 0; k < 8; k++) rmem[k] = 64'hA0 + 64'(k);
    do_txn(0, 1, 64'h1000, '0, 0, 7, -1);
    checks++;
    if (ar_cnt != 1 || aw_cnt != 0 || {ar_addr_seen, ar_len_seen, ar_size_seen, ar_burst_seen}
        !== {64'h1000, 8'd7, 3'd3, 2'b01}) begin errors++;
      $display("FAIL read_ar got cnt %0d addr %h len %0d size %0d burst %0d exp 1 1000 7 3 1",
               ar_cnt, ar_addr_seen, ar_len_seen, ar_size_seen, ar_burst_seen); end
    checks++;
    if (done_cyc != 10) begin errors++;
      $display("FAIL read_latency got %0d exp 10", done_cyc); end
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (data_block_o[k*64 +: 64] !== 64'hA0 + 64'(k)) begin errors++;
        $display("FAIL read_slot%0d got %h exp %h", k, data_block_o[k*64 +: 64],
                 64'hA0 + 64'(k)); end
    end
    // The read block must survive a following write-back.
    do_txn(1, 0, rand_addr(), rand_block(), 0, 7, -1);
    @(negedge clk);
    checks++;
    if (data_block_o !== pack_exp()) begin errors++;
      $display("FAIL read_persist got %h exp %h", data_block_o, pack_exp()); end
  endtask

  task automatic test_backpressure();
    logic [511:0] blk;
    blk = rand_block();
    build_exp_w(blk);
    do_txn(1, 0, 64'h2000_0080, blk, 2, 7, -1);
    checks++;
    if (done_cyc != 15 || unstable != 0) begin errors++;
      $display("FAIL bp_write got done %0d unstable %0d exp 15 0", done_cyc, unstable); end
    checks++;
    if (w_beat_errs() != 0 || wlast_beat != 7) begin errors++;
      $display("FAIL bp_write_beats got bad %0d wlast %0d exp 0 7", w_beat_errs(),
               wlast_beat); end
    @(negedge clk);
    for (int k = 0; k < 8; k++) rmem[k] = {$urandom, $urandom};
    do_txn(0, 1, 64'h3000_0100, '0, 2, 7, -1);
    checks++;
    if (done_cyc != 13 || unstable != 0 || ar_addr_seen !== 64'h3000_0100) begin errors++;
      $display("FAIL bp_read got done %0d unstable %0d addr %h exp 13 0 30000100",
               done_cyc, unstable, ar_addr_seen); end
    @(negedge clk);
    checks++;
    if (data_block_o !== pack_exp()) begin errors++;
      $display("FAIL bp_read_data got %h exp %h", data_block_o, pack_exp()); end
  endtask

  task automatic test_simultaneous();
    logic [511:0] blk;
    blk = rand_block();
    build_exp_w(blk);
    do_txn(1, 1, 64'h4000_0000, blk, 0, 7, -1);
    checks++;
    if (aw_cnt != 1 || ar_cnt != 0 || done_cyc != 11) begin errors++;
      $display("FAIL simul_write_first got aw %0d ar %0d done %0d exp 1 0 11",
               aw_cnt, ar_cnt, done_cyc); end
    checks++;
    if (w_beat_errs() != 0) begin errors++;
      $display("FAIL simul_beats got bad %0d exp 0", w_beat_errs()); end
    @(negedge clk);
    checks++;
    if (state_o !== ST_IDLE || axi.arvalid_o !== 1'b0) begin errors++;
      $display("FAIL simul_idle got state %0d arvalid %b exp 0 0", state_o, axi.arvalid_o); end
    for (int k = 0; k < 8; k++) rmem[k] = {$urandom, $urandom};
    do_txn(0, 1, 64'h4000_0040, '0, 0, 7, -1);
    checks++;
    if (ar_cnt != 1 || done_cyc != 10 || ar_addr_seen !== 64'h4000_0040) begin errors++;
      $display("FAIL simul_read_after got ar %0d done %0d addr %h exp 1 10 40000040",
               ar_cnt, done_cyc, ar_addr_seen); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    for (int k = 0; k < 8; k++) rmem[k] = {$urandom, $urandom};
    do_txn(0, 1, 64'h5000_0000, '0, 0, 7, 3);
    @(negedge clk);
    clear_slave();
    read_start_i = 1'b0;
    arst_i = 1'b1;
    for (int k = 0; k < 8; k++) exp_rbuf[k] = '0;
    #1;
    checks++;
    if ({axi.awvalid_o, axi.wvalid_o, axi.wlast_o, axi.bready_o, axi.arvalid_o,
         axi.rready_o, done_o} !== 7'b0 || state_o !== ST_IDLE) begin errors++;
      $display("FAIL midrst_ctrl got %b state %0d exp 0 0", {axi.awvalid_o, axi.wvalid_o,
               axi.wlast_o, axi.bready_o, axi.arvalid_o, axi.rready_o, done_o}, state_o); end
    checks++;
    if (data_block_o !== pack_exp() || axi.araddr_o !== 64'h0) begin errors++;
      $display("FAIL midrst_data got %h addr %h exp 0 0", data_block_o, axi.araddr_o); end
    @(negedge clk);
    arst_i = 1'b0;
    for (int k = 0; k < 8; k++) rmem[k] = {$urandom, $urandom};
    do_txn(0, 1, 64'h5000_0040, '0, 0, 7, -1);
    checks++;
    if (done_cyc != 10) begin errors++;
      $display("FAIL midrst_next_latency got %0d exp 10", done_cyc); end
    @(negedge clk);
    checks++;
    if (data_block_o !== pack_exp()) begin errors++;
      $display("FAIL midrst_next_data got %h exp %h", data_block_o, pack_exp()); end
  endtask

  task automatic test_early_rlast();
    for (int k = 0; k < 8; k++) rmem[k] = 64'hC0 + 64'(k);
    do_txn(0, 1, 64'h6000_0000, '0, 0, 7, -1);
    @(negedge clk);
    for (int k = 0; k < 8; k++) rmem[k] = 64'hB0 + 64'(k);
    do_txn(0, 1, 64'h6000_0040, '0, 0, 5, -1);
    checks++;
    if (done_cyc != 8) begin errors++;
      $display("FAIL early_rlast_latency got %0d exp 8", done_cyc); end
    @(negedge clk);
    checks++;
    if (data_block_o !== pack_exp()) begin errors++;
      $display("FAIL early_rlast_data got %h exp %h", data_block_o, pack_exp()); end
    checks++;
    if (data_block_o[7*64 +: 64] !== 64'hC7) begin errors++;
      $display("FAIL early_rlast_slot7 got %h exp c7", data_block_o[7*64 +: 64]); end
  endtask

  task automatic test_random();
    logic [511:0] blk;
    logic [63:0]  a;
    bit           wr;
    for (int t = 0; t < 10; t++) begin
      wr = 1'($urandom_range(0, 1));
      a = rand_addr();
      blk = rand_block();
      for (int k = 0; k < 8; k++) rmem[k] = {$urandom, $urandom};
      if (wr) build_exp_w(blk);
      do_txn(wr, !wr, a, blk, 1, 7, -1);
      checks++;
      if (done_cyc != (wr ? 11 : 10) + stall_cyc || unstable != 0) begin errors++;
        $display("FAIL rand%0d_latency got %0d unstable %0d exp %0d 0", t, done_cyc,
                 unstable, (wr ? 11 : 10) + stall_cyc); end
      checks++;
      if (wr ? (aw_addr_seen !== a || w_beat_errs() != 0 || wlast_beat != 7 || ar_cnt != 0)
             : (ar_addr_seen !== a || aw_cnt != 0)) begin errors++;
        $display("FAIL rand%0d_burst got aw %h ar %h bad %0d exp addr %h", t, aw_addr_seen,
                 ar_addr_seen, w_beat_errs(), a); end
      @(negedge clk);
      checks++;
      if (data_block_o !== pack_exp()) begin errors++;
        $display("FAIL rand%0d_rbuf got %h exp %h", t, data_block_o, pack_exp()); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_burst();
    test_early_rlast();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
